// File: rtl/uart_tx_sched_if.sv
// Port bundle between the byte producers, the scheduler and the shared uart_tx.
// Latency: none, wires only.
// Backpressure: producers hold req_valid until req_ack; the UART side is paced by tx_done.
interface uart_tx_sched_if #(
  parameter int NUM_REQ = 4
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ack;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_done;
  logic                 busy;
  logic [IDW-1:0]       grant_id;
  logic                 frame_ok;
  logic                 timeout_err;

  // Scheduler side.
  modport master (
    input  req_valid, req_data, tx_done,
    output req_ack, tx_start, tx_data, busy, grant_id, frame_ok, timeout_err
  );

  // Producer / UART side.
  modport slave (
    output req_valid, req_data, tx_done,
    input  req_ack, tx_start, tx_data, busy, grant_id, frame_ok, timeout_err
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte producers, with frame timeout.
// Latency: req_ack and tx_start rise 1 clk after req_valid is seen in IDLE.
// Backpressure: one frame in flight; other requests stay pending until the gap after the frame ends.
module uart_tx_sched #(
  parameter int NUM_REQ    = 4,
  parameter int START_HOLD = 6000,
  parameter int TIMEOUT    = 200000,
  parameter int GAP_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_sched_if.master  bus
);
  localparam int IDW   = $clog2(NUM_REQ);
  localparam int MAX_A = (START_HOLD > TIMEOUT) ? START_HOLD : TIMEOUT;
  localparam int MAX_C = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
  localparam int CW    = $clog2(MAX_C + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [CW-1:0]  cnt;        // per-state counter, cleared on every state entry
  logic [CW-1:0]  tcnt;       // frame supervision counter, runs from first START cycle
  logic           done_seen;  // tx_done arrived while tx_start was still held

  logic           pick_vld;
  logic [IDW-1:0] pick_idx;
  logic [IDW-1:0] scan_idx;
  logic [7:0]     pick_byte;

  // Scan from ptr upward (mod NUM_REQ); descending loop so the slot nearest ptr wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    scan_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      scan_idx = IDW'((int'(ptr) + i) % NUM_REQ);
      if (bus.req_valid[scan_idx]) begin
        pick_vld = 1'b1;
        pick_idx = scan_idx;
      end
    end
  end

  // Byte mux for the winning requester.
  always_comb begin
    pick_byte = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (IDW'(k) == pick_idx) pick_byte = bus.req_data[8*k +: 8];
    end
  end

  // Frame sequencer: grant, hold tx_start, supervise completion, then enforce the gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      ptr             <= '0;
      cnt             <= '0;
      tcnt            <= '0;
      done_seen       <= 1'b0;
      bus.req_ack     <= '0;
      bus.tx_start    <= 1'b0;
      bus.tx_data     <= '0;
      bus.busy        <= 1'b0;
      bus.grant_id    <= '0;
      bus.frame_ok    <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.req_ack     <= '0;
      bus.frame_ok    <= 1'b0;
      bus.timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state                 <= START;
            bus.req_ack[pick_idx] <= 1'b1;
            bus.tx_data           <= pick_byte;
            bus.grant_id          <= pick_idx;
            bus.tx_start          <= 1'b1;
            bus.busy              <= 1'b1;
            ptr                   <= IDW'((int'(pick_idx) + 1) % NUM_REQ);
            cnt                   <= '0;
            tcnt                  <= '0;
            done_seen             <= 1'b0;
          end
        end
        START: begin
          cnt  <= cnt + 1'b1;
          tcnt <= tcnt + 1'b1;
          if (bus.tx_done) done_seen <= 1'b1;
          if (cnt == CW'(START_HOLD - 1)) begin
            state        <= WAIT_DONE;
            bus.tx_start <= 1'b0;
            cnt          <= '0;
          end
        end
        WAIT_DONE: begin
          tcnt <= tcnt + 1'b1;
          // A completion on the expiry cycle still counts as success.
          if (bus.tx_done || done_seen) begin
            bus.frame_ok <= 1'b1;
            state        <= GAP;
            cnt          <= '0;
          end else if (tcnt == CW'(TIMEOUT - 1)) begin
            bus.timeout_err <= 1'b1;
            state           <= GAP;
            cnt             <= '0;
          end
        end
        GAP: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(GAP_CYCLES - 1)) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            cnt      <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomised bench for uart_tx_sched: scoreboard of expected grants, timing checks against frame rules.
// Latency: expects ack one clk after a request reaches an idle scheduler.
// Backpressure: producers hold requests until acked; a responder plays the UART's tx_done.
module tb_uart_tx_sched;
  localparam int N   = 4;
  localparam int SH  = 6;
  localparam int TO  = 40;
  localparam int GAP = 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  uart_tx_sched_if #(.NUM_REQ(N)) bus ();

  uart_tx_sched #(
    .NUM_REQ(N), .START_HOLD(SH), .TIMEOUT(TO), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct { int id; int data; int d; } exp_t;
  typedef struct { int d; bit stray; } plan_t;

  exp_t  exp_q[$];
  plan_t plan_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    model_last = N - 1;
  int    slot_data [N];

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Round robin: first pending requester strictly after the last one granted.
  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic bit result_ok(input int d);
    return (d >= 0) && (d < TO);
  endfunction

  // Cycle (relative to tx_start rise) at which the result pulse is visible.
  function automatic int result_time(input int d);
    if (!result_ok(d)) return TO;
    if (d < SH) return SH + 1;
    return d + 1;
  endfunction

  task automatic set_req(input int i, input int b);
    slot_data[i] = b;
    bus.req_data[8*i +: 8] = 8'(b);
    bus.req_valid[i] = 1'b1;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_req_ack"},     int'(bus.req_ack), 0);
    check({tag, "_tx_start"},    int'(bus.tx_start), 0);
    check({tag, "_busy"},        int'(bus.busy), 0);
    check({tag, "_frame_ok"},    int'(bus.frame_ok), 0);
    check({tag, "_timeout_err"}, int'(bus.timeout_err), 0);
    check({tag, "_tx_data"},     int'(bus.tx_data), 0);
    check({tag, "_grant_id"},    int'(bus.grant_id), 0);
  endtask

  // Predict the next grant, queue its expectation, then wait for the ack and release that producer.
  task automatic do_frame(input int d, input bit stray, input bit chk_lat);
    int    w;
    int    lat;
    exp_t  e;
    plan_t p;
    w = rr_pick(bus.req_valid, model_last);
    if (w < 0) begin
      fail_now("no_request_pending");
      return;
    end
    e.id = w; e.data = slot_data[w]; e.d = d;
    exp_q.push_back(e);
    p.d = d; p.stray = stray;
    plan_q.push_back(p);
    lat = 0;
    while (lat < 400) begin
      @(negedge clk);
      lat++;
      if (bus.req_ack != '0) break;
    end
    if (bus.req_ack == '0) begin
      fail_now("ack_wait_expired");
      return;
    end
    if (chk_lat) check("grant_latency", lat, 1);
    bus.req_valid = bus.req_valid & ~bus.req_ack;
    model_last = w;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (!bus.busy) break;
    end
    if (bus.busy) fail_now("idle_wait_expired");
  endtask

  function automatic int pick_d();
    int r;
    r = $urandom_range(0, 5);
    if (r == 0) return -1;
    if (r == 1) return TO - 1;
    if (r == 2) return $urandom_range(0, SH - 1);
    return $urandom_range(SH, TO - 2);
  endfunction

  // Monitor state.
  bit   mon_active = 1'b0;
  bit   start_fell = 1'b0;
  bit   res_seen   = 1'b0;
  int   cyc = 0;
  int   t_rise = 0;
  int   t_res = 0;
  int   last_data = 0;
  int   last_id = 0;
  exp_t cur;

  // Monitor: pop an expectation on each ack and follow that frame's timing.
  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        mon_active = 1'b0;
        last_data = 0;
        last_id = 0;
      end else if (bus.req_ack != '0) begin
        if (mon_active) fail_now("ack_inside_frame");
        if (exp_q.size() == 0) begin
          fail_now("unexpected_ack");
        end else begin
          cur = exp_q.pop_front();
          check("req_ack",       int'(bus.req_ack), 1 << cur.id);
          check("grant_id",      int'(bus.grant_id), cur.id);
          check("tx_data",       int'(bus.tx_data), cur.data);
          check("tx_start_rise", int'(bus.tx_start), 1);
          check("busy_rise",     int'(bus.busy), 1);
          mon_active = 1'b1; start_fell = 1'b0; res_seen = 1'b0;
          t_rise = cyc; last_data = cur.data; last_id = cur.id;
        end
      end else if (mon_active) begin
        if (!start_fell && !bus.tx_start) begin
          check("start_hold", cyc - t_rise, SH);
          start_fell = 1'b1;
        end
        if (bus.frame_ok || bus.timeout_err) begin
          if (res_seen) begin
            fail_now("extra_result_pulse");
          end else begin
            check("frame_ok",     int'(bus.frame_ok), int'(result_ok(cur.d)));
            check("timeout_err",  int'(bus.timeout_err), int'(!result_ok(cur.d)));
            check("result_time",  cyc - t_rise, result_time(cur.d));
            check("tx_data_held", int'(bus.tx_data), cur.data);
            res_seen = 1'b1;
            t_res = cyc;
          end
        end
        if (!bus.busy) begin
          if (!res_seen) fail_now("busy_fell_before_result");
          else check("gap_len", cyc - t_res, GAP);
          mon_active = 1'b0;
        end
      end else begin
        check("idle_quiet", int'({bus.tx_start, bus.busy, bus.frame_ok, bus.timeout_err}), 0);
        check("idle_hold", int'(bus.tx_data == 8'(last_data) && bus.grant_id == 2'(last_id)), 1);
      end
    end
  end

  // UART stand-in: answers each tx_start rise with tx_done per the plan, optionally a stray pulse in the gap.
  initial begin : responder
    plan_t p;
    bit    prev;
    int    r;
    int    k_end;
    prev = 1'b0;
    bus.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.tx_start && !prev) begin
        if (plan_q.size() == 0) begin
          fail_now("unplanned_tx_start");
          p.d = -1; p.stray = 1'b0;
        end else begin
          p = plan_q.pop_front();
        end
        r = result_time(p.d);
        k_end = p.stray ? r + 1 : (result_ok(p.d) ? p.d : 0);
        for (int k = 0; k <= k_end; k++) begin
          if (!rst_n) break;
          bus.tx_done = (k == p.d) || (p.stray && k == r + 1);
          @(negedge clk);
        end
        bus.tx_done = 1'b0;
      end
      prev = rst_n && bus.tx_start;
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  // Stimulus: directed scenarios, random traffic, then reset mid-frame.
  initial begin : driver
    int m;
    bus.req_valid = '0;
    bus.req_data = '0;
    for (int i = 0; i < N; i++) slot_data[i] = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 reset_checks("rst0");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request from slot 2.
    set_req(2, 8'hA5);
    do_frame(SH + 5, 1'b0, 1'b1);
    wait_idle();

    // Fairness with every producer re-requesting after its ack.
    for (int i = 0; i < N; i++) set_req(i, (i + 1) * 8'h11);
    for (int f = 0; f < 5; f++) begin
      do_frame(SH + 2 + f, 1'b0, f == 0);
      set_req(model_last, (model_last + 1) * 8'h11);
    end
    for (int f = 0; f < N + 1 && bus.req_valid != '0; f++) do_frame(SH + 1, 1'b1, 1'b0);
    wait_idle();

    // Pointer wrap: 3 first, then 0 and 2.
    set_req(3, 8'h3C);
    do_frame(SH + 3, 1'b0, 1'b1);
    set_req(0, 8'h0F);
    set_req(2, 8'hF0);
    do_frame(SH + 4, 1'b0, 1'b0);
    do_frame(SH + 4, 1'b0, 1'b0);
    wait_idle();

    // Timeout, with a request queued behind it.
    set_req(1, 8'h5A);
    do_frame(-1, 1'b0, 1'b1);
    set_req(3, 8'hC3);
    do_frame(SH + 2, 1'b0, 1'b0);
    wait_idle();

    // Done on the expiry cycle.
    set_req(0, 8'h99);
    do_frame(TO - 1, 1'b0, 1'b1);
    wait_idle();

    // Done while tx_start still held.
    set_req(2, 8'h42);
    do_frame(0, 1'b1, 1'b1);
    set_req(3, 8'h24);
    do_frame(SH - 1, 1'b0, 1'b0);
    wait_idle();

    // Random traffic.
    for (int f = 0; f < 40; f++) begin
      if (bus.req_valid == '0) begin
        wait_idle();
        repeat ($urandom_range(0, 3)) @(negedge clk);
        m = $urandom_range(1, (1 << N) - 1);
        for (int i = 0; i < N; i++) if (m[i]) set_req(i, $urandom_range(0, 255));
        do_frame(pick_d(), 1'($urandom_range(0, 1)), 1'b1);
      end else begin
        do_frame(pick_d(), 1'($urandom_range(0, 1)), 1'b0);
      end
      for (int i = 0; i < N; i++)
        if (!bus.req_valid[i] && $urandom_range(0, 2) == 0) set_req(i, $urandom_range(0, 255));
    end
    for (int f = 0; f < N + 1 && bus.req_valid != '0; f++) do_frame(SH + 3, 1'b0, 1'b0);
    wait_idle();

    // Reset while waiting for tx_done; pointer must restart at 0.
    set_req(1, 8'h77);
    do_frame(-1, 1'b0, 1'b1);
    repeat (SH + 3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 reset_checks("rst_mid");
    bus.req_valid = '0;
    model_last = N - 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_req(0, 8'hE1);
    set_req(1, 8'hE2);
    do_frame(SH + 2, 1'b0, 1'b1);
    do_frame(SH + 2, 1'b0, 1'b0);
    wait_idle();
    repeat (3) @(negedge clk);
    check("exp_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
